prime_cnt_ctrl: RTL and testbench
=================================

# prime_cnt_ctrl

Sequencing controller for the 4-bit JK-flip-flop prime counter (sequence 2, 3, 5, 7, 11, 13, then wrap to 2). It issues `clr` and `step` pulses to the counter at a programmable rate, or one step per request. It checks every returned `count_in` against an internal expected-prime table and presents verified values downstream. A mismatch halts sequencing with a sticky error.

## Interface
Parameters:
- RATE_W, 8, width of the step-period field

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin free-run: clear the counter, then step periodically
- stop  in  1  end free-run
- single  in  1  one step from IDLE
- rate  in  RATE_W  idle cycles between steps; sampled when `start` is accepted; 0 is treated as 1
- count_in  in  4  counter output `Count`
- clr  out  1  counter clear pulse; counter loads 4'd2
- step  out  1  counter advance pulse; counter moves to the next prime on the edge where `step`=1
- value  out  4  last verified prime
- valid  out  1  one-cycle pulse when `value` updates
- wrap  out  1  one-cycle pulse, together with `valid`, when the verified value is 2 following 13
- busy  out  1  high in every state except IDLE and ERR
- err  out  1  sticky mismatch flag

## Operation
- States: IDLE, CLEAR, WAIT, STEP, CHECK, ERR.
- Expected-prime index `idx` (0..5, mapping to 2, 3, 5, 7, 11, 13):
  - Reset value is 0 (the counter also resets to 2).
  - CLEAR sets `idx` to 0.
  - STEP sets `idx` to `(idx+1) mod 6`.
- IDLE:
  - `stop` has priority: with `stop`=1, remain in IDLE.
  - Else `start` → CLEAR, and `rate` is latched into `rate_q` (0 becomes 1).
  - Else `single` → STEP, with the single-shot flag set.
- CLEAR: `clr`=1 for one cycle → CHECK.
- STEP: `step`=1 for one cycle → CHECK.
- CHECK compares `count_in` with `prime[idx]`.
  - On match: `value`←`count_in`, `valid` pulses, and `wrap` pulses if `idx`=0 and the previous state was STEP. Then:
    - single-shot flag set, or stop pending → IDLE, flags cleared;
    - otherwise → WAIT, with the wait counter loaded to `rate_q`.
  - On mismatch: `err`←1 → ERR. `value` is unchanged and there is no `valid` pulse.
- WAIT: counter decrements each cycle; at 1 → STEP. `stop` in WAIT → IDLE on the next edge.
- `stop` in STEP, CLEAR or CHECK sets stop-pending. The current CHECK completes, then the FSM goes to IDLE.
- `start` and `single` are ignored outside IDLE and ERR. `single` is ignored in ERR.
- ERR: `step`=`clr`=0. Only `start` (→ CLEAR, `err` cleared, `rate` re-latched) or `reset` leaves it.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, `idx`=0, `rate_q`=1, wait counter 0, all flags 0;
  - outputs `clr`=`step`=`valid`=`wrap`=`busy`=`err`=0 and `value`=4'd0.
- `clr`, `step` and `busy` decode from the state register; no combinational path from inputs.
- `count_in` must reflect a `step`/`clr` by the following cycle (CHECK).
- Start latency: `start` sampled at edge 0 → CLEAR during cycle 1 → CHECK during cycle 2 → `valid`=1 with `value`=2 during cycle 3.
- Free-run period: `step` pulses every `rate_q`+2 cycles (WAIT ×`rate_q`, STEP, CHECK).
- Single: `single` sampled at edge 0 → STEP in cycle 1 → CHECK in cycle 2 → `valid` in cycle 3, with the FSM back in IDLE.
- Reset asserted mid-sequence aborts immediately: no further `step`, and no `valid` for the in-flight CHECK.

## Test plan
- Reset, then `start` with `rate`=3 and an ideal counter model → `clr` once; `value` sequence 2, 3, 5, 7, 11, 13, 2; `wrap` pulses only on the second 2; `step` spacing 5 cycles.
- `rate`=0 → behaves as `rate`=1; `step` spacing 3 cycles.
- From IDLE after reset, three `single` pulses → `value` 3, 5, 7; each `valid` appears 3 cycles after its request; `busy` low between requests.
- Counter model returns 9 instead of 7 → `err`=1, FSM in ERR, `value` stays 5, no further `step`; then `start` → `err`=0, `clr` pulse, `value`=2.
- `stop` asserted during WAIT → IDLE next cycle, no `step`. `stop` asserted during STEP → the CHECK completes with `valid`, then IDLE. `start` and `stop` together in IDLE → stays in IDLE.
- Assert `reset` during CHECK → all outputs 0 the same cycle; `value`=0 after release.

Source files
------------

// File: rtl/prime_cnt_ctrl.sv
// prime_cnt_ctrl
//   Sequencing controller for the 4-bit JK prime counter (2,3,5,7,11,13,wrap).
//   Issues clr/step pulses to the counter either periodically (free-run) or
//   once per request (single), checks each returned count against the
//   expected prime, and forwards verified values. A mismatch parks the
//   controller in ERR with a sticky err flag until the next start.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     begin free-run (accepted in IDLE and ERR)
//   stop      end free-run (has priority over start/single in IDLE)
//   single    one step from IDLE
//   rate      idle cycles between steps, latched on start (0 behaves as 1)
//   count_in  counter output, valid one cycle after clr/step
//   clr       counter clear pulse (counter loads 2)
//   step      counter advance pulse
//   value     last verified prime
//   valid     one-cycle pulse when value updates
//   wrap      one-cycle pulse with valid when 2 follows 13
//   busy      high outside IDLE and ERR
//   err       sticky mismatch flag
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start or single
//   S_CLEAR | clr pulse to counter, expected index reset to 0
//   S_WAIT  | down-counting rate_q cycles before the next step
//   S_STEP  | step pulse to counter, expected index advances
//   S_CHECK | compare count_in with the expected prime
//   S_ERR   | mismatch seen; outputs quiet until start
module prime_cnt_ctrl #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic [RATE_W-1:0] rate,
  input  logic [3:0]        count_in,
  output logic              clr,
  output logic              step,
  output logic [3:0]        value,
  output logic              valid,
  output logic              wrap,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_CHECK = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        idx;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] wcnt;
  logic              single_f;
  logic              stop_pend;
  logic              from_step;

  // control strobes from the next-state logic to the datapath registers
  logic ld_rate;
  logic idx_clr;
  logic idx_inc;
  logic ld_wait;
  logic dec_wait;
  logic set_single;
  logic set_stop;
  logic clr_flags;
  logic upd_value;
  logic set_err;
  logic clr_err;

  logic              match;
  logic [RATE_W-1:0] rate_eff;

  function automatic logic [3:0] prime_at(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'd2;
      3'd1:    p = 4'd3;
      3'd2:    p = 4'd5;
      3'd3:    p = 4'd7;
      3'd4:    p = 4'd11;
      default: p = 4'd13;
    endcase
    return p;
  endfunction

  assign match    = (count_in == prime_at(idx));
  // a zero rate would leave the wait timer with no terminal count
  assign rate_eff = (rate == '0) ? RATE_W'(1) : rate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_rate    = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    ld_wait    = 1'b0;
    dec_wait   = 1'b0;
    set_single = 1'b0;
    set_stop   = 1'b0;
    clr_flags  = 1'b0;
    upd_value  = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!stop) begin
          if (start) begin
            state_nxt = S_CLEAR;
            ld_rate   = 1'b1;
            clr_flags = 1'b1;
          end else if (single) begin
            state_nxt  = S_STEP;
            set_single = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        idx_clr   = 1'b1;
        set_stop  = stop;
        state_nxt = S_CHECK;
      end

      S_STEP: begin
        idx_inc   = 1'b1;
        set_stop  = stop;
        state_nxt = S_CHECK;
      end

      S_CHECK: begin
        if (match) begin
          upd_value = 1'b1;
          // a stop seen in this very cycle also ends the run here
          if (single_f || stop_pend || stop) begin
            state_nxt = S_IDLE;
            clr_flags = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            ld_wait   = 1'b1;
          end
        end else begin
          set_err   = 1'b1;
          clr_flags = 1'b1;
          state_nxt = S_ERR;
        end
      end

      S_WAIT: begin
        dec_wait = 1'b1;
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (wcnt <= RATE_W'(1)) begin
          state_nxt = S_STEP;
        end
      end

      S_ERR: begin
        if (start) begin
          state_nxt = S_CLEAR;
          ld_rate   = 1'b1;
          clr_err   = 1'b1;
          clr_flags = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 3'd0;
      rate_q    <= RATE_W'(1);
      wcnt      <= '0;
      single_f  <= 1'b0;
      stop_pend <= 1'b0;
      from_step <= 1'b0;
      value     <= 4'd0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // remembers whether the cycle before CHECK was a step (not a clear)
      from_step <= (state == S_STEP);

      valid <= upd_value;
      wrap  <= upd_value && (idx == 3'd0) && from_step;
      if (upd_value) begin
        value <= count_in;
      end

      if (ld_rate) begin
        rate_q <= rate_eff;
      end

      if (idx_clr) begin
        idx <= 3'd0;
      end else if (idx_inc) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end

      if (ld_wait) begin
        wcnt <= rate_q;
      end else if (dec_wait) begin
        wcnt <= wcnt - RATE_W'(1);
      end

      if (clr_flags) begin
        single_f  <= 1'b0;
        stop_pend <= 1'b0;
      end else begin
        if (set_single) begin
          single_f <= 1'b1;
        end
        if (set_stop) begin
          stop_pend <= 1'b1;
        end
      end

      if (set_err) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

  // pure state decodes: no path from any input to these outputs
  assign clr  = (state == S_CLEAR);
  assign step = (state == S_STEP);
  assign busy = (state != S_IDLE) && (state != S_ERR);

endmodule

// File: tb/tb_prime_cnt_ctrl.sv
module tb_prime_cnt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, single;
  logic [7:0] rate;
  logic [3:0] count_in;
  logic       clr, step, valid, wrap, busy, err;
  logic [3:0] value;
  bit         bad7;

  prime_cnt_ctrl #(.RATE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .single(single),
    .rate(rate), .count_in(count_in), .clr(clr), .step(step), .value(value),
    .valid(valid), .wrap(wrap), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // counter stand-in; bad7 makes it read back 9 whenever it holds 7
  logic [3:0] cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 4'd2;
    else if (clr) cnt <= 4'd2;
    else if (step) begin
      case (cnt)
        4'd2: cnt <= 4'd3;
        4'd3: cnt <= 4'd5;
        4'd5: cnt <= 4'd7;
        4'd7: cnt <= 4'd11;
        4'd11: cnt <= 4'd13;
        default: cnt <= 4'd2;
      endcase
    end
  end
  assign count_in = (bad7 && cnt == 4'd7) ? 4'd9 : cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int primes[6] = '{2, 3, 5, 7, 11, 13};
  int exp_a[7]  = '{2, 3, 5, 7, 11, 13, 2};
  int exp_c[3]  = '{3, 5, 7};
  int rq[3];

  // reference model: a run is described by its elapsed time m_t since its
  // first pulse and its period m_p; pulses fall on multiples of m_p,
  // checks one cycle after a pulse
  localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;
  int         m_mode, m_t, m_p, m_pos;
  bit         m_single, m_stoppend, m_valid, m_wrap, m_err;
  logic [3:0] m_value;

  int step_q[$], val_q[$], vcyc_q[$], wrap_q[$];
  int clr_n;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_t = 0; m_p = 1; m_pos = 0;
    m_single = 0; m_stoppend = 0; m_valid = 0; m_wrap = 0; m_err = 0;
    m_value = 4'd0;
  endfunction

  function automatic void begin_run(bit one);
    m_mode = M_RUN; m_t = 0; m_single = one; m_stoppend = 0;
    m_p = one ? 1000000 : (((rate == 8'd0) ? 1 : int'(rate)) + 2);
  endfunction

  function automatic void model_update();
    int ph;
    bit nv, nw;
    nv = 0; nw = 0;
    case (m_mode)
      M_IDLE: if (!stop) begin
        if (start) begin_run(0);
        else if (single) begin_run(1);
      end
      M_ERR: if (start) begin begin_run(0); m_err = 0; end
      default: begin
        ph = m_t % m_p;
        if (ph == 0) begin
          m_pos = (m_t == 0 && !m_single) ? 0 : (m_pos + 1) % 6;
          if (stop) m_stoppend = 1;
        end else if (ph == 1) begin
          if (bad7 && primes[m_pos] == 7) begin
            m_err = 1; m_mode = M_ERR;
          end else begin
            m_value = 4'(primes[m_pos]);
            nv = 1;
            nw = (m_pos == 0) && !(m_t == 1 && !m_single);
            if (m_single || m_stoppend || stop) m_mode = M_IDLE;
          end
        end else if (stop) begin
          m_mode = M_IDLE;
        end
        m_t++;
      end
    endcase
    m_valid = nv; m_wrap = nw;
  endfunction

  function automatic void compare_all();
    bit run, e_clr, e_step;
    run    = (m_mode == M_RUN);
    e_clr  = run && (m_t == 0) && !m_single;
    e_step = run && ((m_t % m_p) == 0) && !e_clr;
    chk("clr", int'(clr), int'(e_clr));
    chk("step", int'(step), int'(e_step));
    chk("busy", int'(busy), int'(run));
    chk("valid", int'(valid), int'(m_valid));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("err", int'(err), int'(m_err));
    chk("value", int'(value), int'(m_value));
  endfunction

  function automatic void clear_rec();
    step_q.delete(); val_q.delete(); vcyc_q.delete(); wrap_q.delete(); clr_n = 0;
  endfunction

  function automatic void record();
    if (step) step_q.push_back(cyc);
    if (clr) clr_n++;
    if (valid) begin
      val_q.push_back(int'(value));
      vcyc_q.push_back(cyc);
      if (wrap) wrap_q.push_back(val_q.size() - 1);
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    compare_all();
    record();
    @(posedge clk);
    if (!reset) model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; single = 0;
  endtask

  task automatic hard_reset();
    idle_in(); bad7 = 0;
    reset = 1; model_reset();
    cycle(); cycle();
    reset = 0;
  endtask

  task automatic reset_mid();
    #2 reset = 1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    cyc++;
    #1 reset = 0;
  endtask

  initial begin
    idle_in(); rate = 8'd0; bad7 = 0; reset = 1;
    model_reset();
    @(posedge clk); #1;
    hard_reset();
    chk("rst_value", int'(value), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // free-run, rate 3
    clear_rec();
    rq[0] = cyc; rate = 8'd3; start = 1; cycle(); start = 0;
    repeat (35) cycle();
    chk("A_clr_count", clr_n, 1);
    chk("A_nvalid", val_q.size(), 7);
    for (int i = 0; i < val_q.size() && i < 7; i++) chk("A_value_seq", val_q[i], exp_a[i]);
    if (vcyc_q.size() > 0) chk("A_start_latency", vcyc_q[0] - rq[0], 3);
    chk("A_nwrap", wrap_q.size(), 1);
    if (wrap_q.size() > 0) chk("A_wrap_pos", wrap_q[0], 6);
    chk("A_nstep", step_q.size(), 6);
    for (int i = 1; i < step_q.size(); i++) chk("A_step_spacing", step_q[i] - step_q[i-1], 5);
    stop = 1; cycle(); stop = 0; repeat (6) cycle();

    // rate 0 behaves as 1
    hard_reset(); clear_rec();
    rate = 8'd0; start = 1; cycle(); start = 0;
    repeat (14) cycle();
    chk("B_nstep", step_q.size(), 4);
    for (int i = 1; i < step_q.size(); i++) chk("B_step_spacing", step_q[i] - step_q[i-1], 3);
    stop = 1; cycle(); stop = 0; repeat (4) cycle();

    // single steps from IDLE
    hard_reset(); clear_rec();
    for (int k = 0; k < 3; k++) begin
      rq[k] = cyc; single = 1; cycle(); single = 0;
      repeat (4) cycle();
      chk("C_busy_gap", int'(busy), 0);
    end
    chk("C_nvalid", val_q.size(), 3);
    for (int k = 0; k < val_q.size() && k < 3; k++) begin
      chk("C_value", val_q[k], exp_c[k]);
      chk("C_latency", vcyc_q[k] - rq[k], 3);
    end

    // mismatch on the fourth prime
    hard_reset(); clear_rec();
    bad7 = 1; rate = 8'd1; start = 1; cycle(); start = 0;
    repeat (20) cycle();
    chk("D_nvalid", val_q.size(), 3);
    for (int k = 0; k < val_q.size() && k < 3; k++) chk("D_value", val_q[k], primes[k]);
    clear_rec();
    single = 1; cycle(); single = 0;
    repeat (9) cycle();
    chk("D_steps_in_err", step_q.size(), 0);
    chk("D_err", int'(err), 1);
    chk("D_value_held", int'(value), 5);
    chk("D_busy", int'(busy), 0);
    bad7 = 0; start = 1; cycle(); start = 0;
    chk("D_err_cleared", int'(err), 0);
    chk("D_clr", int'(clr), 1);
    cycle(); cycle();
    chk("D_restart_valid", int'(valid), 1);
    chk("D_restart_value", int'(value), 2);
    stop = 1; cycle(); stop = 0; repeat (4) cycle();

    // stop in WAIT, stop in STEP, start+stop in IDLE
    hard_reset(); clear_rec();
    rate = 8'd4; start = 1; cycle(); start = 0;
    repeat (3) cycle();
    stop = 1; cycle(); stop = 0;
    chk("E_wait_stop_busy", int'(busy), 0);
    clear_rec(); repeat (6) cycle();
    chk("E_wait_stop_steps", step_q.size(), 0);
    rate = 8'd2; start = 1; cycle(); start = 0;
    repeat (4) cycle();
    chk("E_in_step", int'(step), 1);
    stop = 1; cycle(); stop = 0;
    chk("E_check_busy", int'(busy), 1);
    cycle();
    chk("E_check_valid", int'(valid), 1);
    chk("E_check_value", int'(value), 3);
    chk("E_check_idle", int'(busy), 0);
    start = 1; stop = 1; cycle(); idle_in();
    chk("E_start_stop_busy", int'(busy), 0);
    chk("E_start_stop_clr", int'(clr), 0);

    // reset during CHECK
    hard_reset();
    rate = 8'd2; start = 1; cycle(); start = 0;
    cycle();
    reset_mid();
    chk("F_busy", int'(busy), 0);
    chk("F_step", int'(step), 0);
    chk("F_valid", int'(valid), 0);
    chk("F_value", int'(value), 0);
    repeat (3) cycle();
    chk("F_no_valid_after", int'(valid), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 11) == 0);
      single = ($urandom_range(0, 7) == 0);
      rate   = 8'($urandom_range(0, 5));
      if (m_mode != M_RUN && $urandom_range(0, 19) == 0) bad7 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) reset_mid();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
